hams_merge_4way: RTL and testbench

Four-lane streaming merge unit for the HAMS merge phase. It accepts one element per lane per cycle from the four column memories. Each lane element is buffered in a small per-lane FIFO. The unit presents the minimum head element among the lanes whose current run is not yet exhausted, as a show-ahead output. `hams_merge_sort_ctrl` drives the pushes (`unsort_data_out` / `unsort_data_out_vld`), issues pops, and writes the presented element back to memory or to the sorted output stream.

---
 rtl/hams_merge_4way_if.sv | 28 ++
 rtl/hams_merge_4way.sv | 166 ++++++++++++++++
 tb/tb_hams_merge_4way.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hams_merge_4way_if.sv
// Push/pop handshake bundle between hams_merge_sort_ctrl (master) and hams_merge_4way (slave).
// Each pair is {key, value}; key occupies the upper DATA_WIDTH/2 bits.
interface hams_merge_4way_if #(
   parameter int NUM_MEM    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int RUN_WIDTH  = 11
);
   logic                               start;
   logic [RUN_WIDTH-1:0]               run_len;
   logic [NUM_MEM-1:0][DATA_WIDTH-1:0] unsort_data_in;
   logic [NUM_MEM-1:0]                 unsort_data_in_vld;
   logic                               fifo_pop;
   logic [DATA_WIDTH-1:0]              merge_sort_data;
   logic                               merge_sort_data_vld;
   logic                               fifo_full;
   logic                               fifo_empty;
   logic                               run_done;

   modport master (
      output start, run_len, unsort_data_in, unsort_data_in_vld, fifo_pop,
      input  merge_sort_data, merge_sort_data_vld, fifo_full, fifo_empty, run_done
   );

   modport slave (
      input  start, run_len, unsort_data_in, unsort_data_in_vld, fifo_pop,
      output merge_sort_data, merge_sort_data_vld, fifo_full, fifo_empty, run_done
   );
endinterface

// File: rtl/hams_merge_4way.sv
// Four-lane show-ahead merge: per-lane FIFOs, presents the minimum key among lanes with run left.
// Optional sticky error flag on dropped pushes / stray pops when HAMS_MERGE_ERR_EN is defined.
module hams_merge_4way #(
   parameter int NUM_MEM    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int RUN_WIDTH  = 11
) (
   input  logic             clk,
   input  logic             rst,
`ifdef HAMS_MERGE_ERR_EN
   output logic             merge_err,
`endif
   hams_merge_4way_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int KEY_W = DATA_WIDTH / 2;
   localparam int SEL_W = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_MERGE  = 2'd1;
   localparam logic [1:0] ST_RELOAD = 2'd2;

   logic [1:0]                        state_q, state_d;
   logic [RUN_WIDTH-1:0]              run_len_q, run_len_d;
   logic [NUM_MEM-1:0][RUN_WIDTH-1:0] rem_q, rem_d;
   logic [NUM_MEM-1:0][CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_MEM-1:0][PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [NUM_MEM-1:0][PTR_W-1:0]     wr_ptr_q, wr_ptr_d;

   logic [DATA_WIDTH-1:0] head [NUM_MEM];
   logic [NUM_MEM-1:0]    active;
   logic [NUM_MEM-1:0]    ready;
   logic [NUM_MEM-1:0]    push_acc;
   logic [NUM_MEM-1:0]    near_full;
   logic [NUM_MEM-1:0]    pop_lane;
   logic                  vld;
   logic                  pop_ok;
   logic [SEL_W-1:0]      sel_idx;
   logic [DATA_WIDTH-1:0] sel_data;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MEM; gi++) begin : g_lane
         logic [DATA_WIDTH-1:0] lane_mem [FIFO_DEPTH];

         always_ff @(posedge clk) begin
            if (push_acc[gi]) begin
               lane_mem[wr_ptr_q[gi]] <= bus.unsort_data_in[gi];
            end
         end

         assign head[gi]      = lane_mem[rd_ptr_q[gi]];
         assign active[gi]    = (state_q == ST_MERGE) && (rem_q[gi] != '0);
         assign ready[gi]     = !active[gi] || (cnt_q[gi] != '0);
         assign near_full[gi] = (cnt_q[gi] >= CNT_W'(FIFO_DEPTH - 2));
         // A full lane still takes a push when the same lane is popped this cycle.
         assign push_acc[gi]  = bus.unsort_data_in_vld[gi] && !bus.start && (state_q != ST_IDLE) &&
                                ((cnt_q[gi] != CNT_W'(FIFO_DEPTH)) || pop_lane[gi]);
      end
   endgenerate

   // Strict less-than keeps the lowest lane index on equal keys.
   always_comb begin
      logic found;
      found    = 1'b0;
      sel_idx  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_MEM; i++) begin
         if (active[i] && (cnt_q[i] != '0) &&
             (!found || (head[i][DATA_WIDTH-1 -: KEY_W] < sel_data[DATA_WIDTH-1 -: KEY_W]))) begin
            found    = 1'b1;
            sel_idx  = SEL_W'(i);
            sel_data = head[i];
         end
      end
   end

   assign vld      = (state_q == ST_MERGE) && (|active) && (&ready);
   assign pop_ok   = bus.fifo_pop && vld && !bus.start;
   assign pop_lane = pop_ok ? (NUM_MEM'(1) << sel_idx) : '0;

   always_comb begin
      state_d   = state_q;
      run_len_d = run_len_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      for (int i = 0; i < NUM_MEM; i++) begin
         if (push_acc[i]) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
         end
         if (pop_lane[i]) begin
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            rem_d[i]    = rem_q[i] - RUN_WIDTH'(1);
         end
         cnt_d[i] = cnt_q[i] + CNT_W'(push_acc[i]) - CNT_W'(pop_lane[i]);
      end
      case (state_q)
         ST_IDLE:   state_d = ST_IDLE;
         ST_MERGE:  if (pop_ok && (rem_d == '0)) state_d = ST_RELOAD;
         // Queued FIFO data belongs to the next group, so only the run counters reload.
         ST_RELOAD: begin
            rem_d   = {NUM_MEM{run_len_q}};
            state_d = ST_MERGE;
         end
         default:   state_d = ST_IDLE;
      endcase
      if (bus.start) begin
         run_len_d = bus.run_len;
         cnt_d     = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         rem_d     = {NUM_MEM{bus.run_len}};
         state_d   = (bus.run_len != '0) ? ST_MERGE : ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         run_len_q <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         run_len_q <= run_len_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
      end
   end

   assign bus.merge_sort_data     = sel_data;
   assign bus.merge_sort_data_vld = vld;
   assign bus.fifo_full           = |near_full;
   assign bus.fifo_empty          = (cnt_q == '0);
   assign bus.run_done            = (state_q == ST_RELOAD);

`ifdef HAMS_MERGE_ERR_EN
   logic merge_err_q, merge_err_d;

   always_comb begin
      merge_err_d = merge_err_q;
      if (bus.start) begin
         merge_err_d = 1'b0;
      end else if ((|(bus.unsort_data_in_vld & ~push_acc)) || (bus.fifo_pop && !vld)) begin
         merge_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) merge_err_q <= 1'b0;
      else     merge_err_q <= merge_err_d;
   end

   assign merge_err = merge_err_q;
`endif

endmodule

// File: tb/tb_hams_merge_4way.sv
// Self-checking bench for hams_merge_4way: vector table, directed corner sequences and a
// randomized phase compared every cycle against a queue-based reference model.
module tb_hams_merge_4way;
   localparam int NM = 4;
   localparam int DW = 32;
   localparam int FD = 8;
   localparam int RW = 11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hams_merge_4way_if #(.NUM_MEM(NM), .DATA_WIDTH(DW), .RUN_WIDTH(RW)) bus ();
`ifdef HAMS_MERGE_ERR_EN
   logic merge_err;
`endif

   hams_merge_4way #(.NUM_MEM(NM), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .RUN_WIDTH(RW)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef HAMS_MERGE_ERR_EN
      .merge_err (merge_err),
`endif
      .bus       (bus)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_model = 1'b0;

   // Reference model: plain queues per lane plus run bookkeeping.
   logic [DW-1:0] mq [NM][$];
   int m_rem [NM];
   int m_mode;   // 0 idle, 1 merging, 2 reload cycle
   int m_rl;
`ifdef HAMS_MERGE_ERR_EN
   bit m_err;
`endif

   typedef struct {
      logic             start;
      logic [RW-1:0]    rl;
      logic [NM-1:0]    pv;
      logic [NM-1:0][15:0] keys;
      logic             pop;
      logic             e_vld;
      logic [15:0]      e_key;
      logic             e_done;
      logic             e_empty;
   } vec_t;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int k, input int v);
      logic [DW-1:0] p;
      p = {k[15:0], v[15:0]};
      return p;
   endfunction

   function automatic logic [15:0] key_of(input logic [DW-1:0] p);
      return p[31:16];
   endfunction

   function automatic int m_sel();
      int s = -1;
      for (int i = 0; i < NM; i++) begin
         if (m_mode == 1 && m_rem[i] != 0 && mq[i].size() != 0) begin
            if (s < 0) s = i;
            else if (key_of(mq[i][0]) < key_of(mq[s][0])) s = i;
         end
      end
      return s;
   endfunction

   function automatic bit m_vld();
      bit any = 1'b0;
      if (m_mode != 1) return 1'b0;
      for (int i = 0; i < NM; i++) begin
         if (m_rem[i] != 0) begin
            any = 1'b1;
            if (mq[i].size() == 0) return 1'b0;
         end
      end
      return any;
   endfunction

   function automatic bit m_full();
      for (int i = 0; i < NM; i++) if (mq[i].size() >= FD - 2) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_empty();
      for (int i = 0; i < NM; i++) if (mq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_flag_err();
`ifdef HAMS_MERGE_ERR_EN
      m_err = 1'b1;
`endif
   endtask

   task automatic m_reset();
      for (int i = 0; i < NM; i++) begin
         mq[i].delete();
         m_rem[i] = 0;
      end
      m_mode = 0;
      m_rl   = 0;
`ifdef HAMS_MERGE_ERR_EN
      m_err  = 1'b0;
`endif
   endtask

   task automatic model_step(input bit r, input bit s, input int rl, input logic [NM-1:0] pv,
                             input logic [NM-1:0][DW-1:0] pd, input bit p);
      bit v;
      int sel;
      bit all_zero;
      if (r) begin
         m_reset();
         return;
      end
      if (s) begin
         m_reset();
         m_rl = rl;
         if (rl != 0) begin
            m_mode = 1;
            for (int i = 0; i < NM; i++) m_rem[i] = rl;
         end
         return;
      end
      v   = m_vld();
      sel = m_sel();
      if (p && !v) m_flag_err();
      if (p && v) begin
         mq[sel].delete(0);
         m_rem[sel]--;
      end
      for (int i = 0; i < NM; i++) begin
         if (pv[i]) begin
            if (m_mode != 0 && mq[i].size() < FD) mq[i].push_back(pd[i]);
            else m_flag_err();
         end
      end
      if (m_mode == 2) begin
         m_mode = 1;
         for (int i = 0; i < NM; i++) m_rem[i] = m_rl;
      end else if (p && v) begin
         all_zero = 1'b1;
         for (int i = 0; i < NM; i++) if (m_rem[i] != 0) all_zero = 1'b0;
         if (all_zero) m_mode = 2;
      end
   endtask

   task automatic compare_model();
      int s;
      check("vld", bus.merge_sort_data_vld, m_vld());
      if (m_vld()) begin
         s = m_sel();
         check("data", bus.merge_sort_data, mq[s][0]);
      end
      check("full", bus.fifo_full, m_full());
      check("empty", bus.fifo_empty, m_empty());
      check("run_done", bus.run_done, (m_mode == 2));
`ifdef HAMS_MERGE_ERR_EN
      check("merge_err", merge_err, m_err);
`endif
   endtask

   task automatic clr_in();
      bus.start              = 1'b0;
      bus.run_len            = '0;
      bus.unsort_data_in_vld = '0;
      bus.unsort_data_in     = '0;
      bus.fifo_pop           = 1'b0;
   endtask

   // Outputs depend only on registered state, so they are compared #1 after the edge.
   task automatic tick();
      bit r, s, p;
      logic [RW-1:0] rl;
      logic [NM-1:0] pv;
      logic [NM-1:0][DW-1:0] pd;
      if (chk_model) compare_model();
      r  = rst;
      s  = bus.start;
      rl = bus.run_len;
      pv = bus.unsort_data_in_vld;
      pd = bus.unsort_data_in;
      p  = bus.fifo_pop;
      @(posedge clk);
      model_step(r, s, int'(rl), pv, pd, p);
      #1;
   endtask

   task automatic begin_pass(input int rl);
      clr_in();
      bus.start   = 1'b1;
      bus.run_len = RW'(rl);
      tick();
      clr_in();
   endtask

   initial begin
      vec_t tbl [8];
      logic [DW-1:0] got [$];
      int dones, first_c, last_c;

      tbl[0] = '{1'b1, 11'd1, 4'b0000, 64'h0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 11'd0, 4'b1111, 64'h0001_0009_0003_0007, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 11'd0, 4'b0000, 64'h0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 11'd0, 4'b0000, 64'h0, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 11'd0, 4'b0000, 64'h0, 1'b1, 1'b1, 16'd7, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 11'd0, 4'b0000, 64'h0, 1'b1, 1'b1, 16'd9, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 11'd0, 4'b0000, 64'h0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1};
      tbl[7] = '{1'b0, 11'd0, 4'b0000, 64'h0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};

      rst = 1'b1;
      clr_in();
      m_reset();
      tick();
      tick();
      rst = 1'b0;
      chk_model = 1'b1;

      check("rst_data", bus.merge_sort_data, '0);
      check("rst_vld", bus.merge_sort_data_vld, 1'b0);
      check("rst_done", bus.run_done, 1'b0);
      check("rst_full", bus.fifo_full, 1'b0);
      check("rst_empty", bus.fifo_empty, 1'b1);

      // Basic 4-element merge from the vector table.
      for (int r = 0; r < 8; r++) begin
         bus.start              = tbl[r].start;
         bus.run_len            = tbl[r].rl;
         bus.unsort_data_in_vld = tbl[r].pv;
         for (int i = 0; i < NM; i++) bus.unsort_data_in[i] = {tbl[r].keys[i], 16'(i)};
         bus.fifo_pop           = tbl[r].pop;
         check($sformatf("tbl%0d_vld", r), bus.merge_sort_data_vld, tbl[r].e_vld);
         if (tbl[r].e_vld) check($sformatf("tbl%0d_key", r), key_of(bus.merge_sort_data), tbl[r].e_key);
         check($sformatf("tbl%0d_done", r), bus.run_done, tbl[r].e_done);
         check($sformatf("tbl%0d_empty", r), bus.fifo_empty, tbl[r].e_empty);
         tick();
         clr_in();
         $display("tbl row %0d applied", r);
      end

      // Tie-break: equal keys drain lane 0 first, then 1, 2, 3.
      begin_pass(2);
      got.delete();
      dones = 0;
      for (int c = 0; c < 16; c++) begin
         if (c < 2) begin
            bus.unsort_data_in_vld = '1;
            for (int i = 0; i < NM; i++) bus.unsort_data_in[i] = mk(5, i * 2 + c);
         end
         if (bus.run_done) dones++;
         if (bus.merge_sort_data_vld) begin
            got.push_back(bus.merge_sort_data);
            bus.fifo_pop = 1'b1;
         end
         tick();
         clr_in();
      end
      check("tie_count", got.size(), 8);
      for (int k = 0; k < 8; k++)
         check($sformatf("tie_order%0d", k), (k < got.size()) ? {16'd0, got[k][15:0]} : 32'hDEAD, k);
      check("tie_done", dones, 1);
      $display("tie-break sequence: %0d outputs, %0d run_done", got.size(), dones);

      // Stall: lane 2 arrives three cycles late; output must wait, then stay sorted.
      begin_pass(4);
      got.delete();
      dones = 0;
      for (int c = 0; c < 30; c++) begin
         for (int i = 0; i < NM; i++) begin
            if (i != 2 && c < 4) begin
               bus.unsort_data_in_vld[i] = 1'b1;
               bus.unsort_data_in[i] = mk(c * 4 + i, c);
            end
            if (i == 2 && c >= 3 && c < 7) begin
               bus.unsort_data_in_vld[i] = 1'b1;
               bus.unsort_data_in[i] = mk((c - 3) * 4 + 2, c - 3);
            end
         end
         if (c >= 1 && c <= 3) check($sformatf("stall_vld_low%0d", c), bus.merge_sort_data_vld, 1'b0);
         if (c == 4) check("stall_vld_rise", bus.merge_sort_data_vld, 1'b1);
         if (bus.run_done) dones++;
         if (bus.merge_sort_data_vld) begin
            got.push_back(bus.merge_sort_data);
            bus.fifo_pop = 1'b1;
         end
         tick();
         clr_in();
      end
      check("stall_count", got.size(), 16);
      for (int k = 0; k < 16 && k < got.size(); k++)
         check($sformatf("stall_key%0d", k), key_of(got[k]), k);
      check("stall_done", dones, 1);
      $display("stall sequence: %0d outputs, %0d run_done", got.size(), dones);

      // Group rollover: two groups of 16 with only the reload cycle as a bubble.
      begin_pass(4);
      got.delete();
      dones = 0;
      first_c = -1;
      last_c = -1;
      for (int c = 0; c < 45; c++) begin
         if (c < 8) begin
            bus.unsort_data_in_vld = '1;
            for (int i = 0; i < NM; i++) bus.unsort_data_in[i] = mk(c * 4 + i, c);
         end
         if (bus.run_done) dones++;
         if (bus.merge_sort_data_vld) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            got.push_back(bus.merge_sort_data);
            bus.fifo_pop = 1'b1;
         end
         tick();
         clr_in();
      end
      check("roll_count", got.size(), 32);
      for (int k = 0; k < 32 && k < got.size(); k++)
         check($sformatf("roll_key%0d", k), key_of(got[k]), k);
      check("roll_done", dones, 2);
      check("roll_span", last_c - first_c, 32);
      $display("rollover sequence: %0d outputs, %0d run_done", got.size(), dones);

      // Backpressure on lane 0: full at occupancy 6, ninth push dropped.
      begin_pass(16);
      for (int c = 0; c < 10; c++) begin
         check($sformatf("bp_full%0d", c), bus.fifo_full, (c >= 6));
         if (c < 9) begin
            bus.unsort_data_in_vld[0] = 1'b1;
            bus.unsort_data_in[0] = mk(c, c);
         end
         tick();
         clr_in();
      end
`ifdef HAMS_MERGE_ERR_EN
      check("bp_err", merge_err, 1'b1);
`endif
      bus.unsort_data_in_vld = 4'b1110;
      for (int i = 1; i < NM; i++) bus.unsort_data_in[i] = mk(16'hFFFF, i);
      tick();
      clr_in();
      got.delete();
      for (int c = 0; c < 14; c++) begin
         if (bus.merge_sort_data_vld) begin
            got.push_back(bus.merge_sort_data);
            bus.fifo_pop = 1'b1;
         end
         tick();
         clr_in();
      end
      check("bp_drained", got.size(), 8);
      if (got.size() != 0) check("bp_last_key", key_of(got[got.size() - 1]), 7);
      $display("backpressure sequence: %0d lane-0 outputs", got.size());

      // Reset and zero-length restart in the middle of a pass.
      begin_pass(4);
      for (int c = 0; c < 2; c++) begin
         bus.unsort_data_in_vld = '1;
         for (int i = 0; i < NM; i++) bus.unsort_data_in[i] = mk(1, i);
         tick();
         clr_in();
      end
      check("rp_nonempty", bus.fifo_empty, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rp_rst_empty", bus.fifo_empty, 1'b1);
      check("rp_rst_vld", bus.merge_sort_data_vld, 1'b0);
      bus.unsort_data_in_vld = 4'b0001;
      bus.unsort_data_in[0] = mk(2, 0);
      tick();
      clr_in();
      check("rp_idle_drop", bus.fifo_empty, 1'b1);
      begin_pass(4);
      bus.unsort_data_in_vld = '1;
      tick();
      clr_in();
      check("rp_nonempty2", bus.fifo_empty, 1'b0);
      begin_pass(0);
      check("rp_start0_empty", bus.fifo_empty, 1'b1);
      check("rp_start0_vld", bus.merge_sort_data_vld, 1'b0);
      bus.unsort_data_in_vld = '1;
      tick();
      clr_in();
      check("rp_start0_drop", bus.fifo_empty, 1'b1);
      $display("reset/restart sequence done");

      // Randomized traffic against the reference model.
      for (int n = 0; n < 1500; n++) begin
         if (n % 300 == 0) begin
            bus.start   = 1'b1;
            bus.run_len = RW'($urandom_range(1, 6));
         end else begin
            if ($urandom_range(0, 199) == 0) begin
               bus.start   = 1'b1;
               bus.run_len = RW'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            bus.unsort_data_in_vld = NM'($urandom_range(0, 15) & $urandom_range(0, 15));
            for (int i = 0; i < NM; i++)
               bus.unsort_data_in[i] = mk($urandom_range(0, 15), $urandom_range(0, 65535));
            bus.fifo_pop = ($urandom_range(0, 3) != 0);
         end
         tick();
         clr_in();
         rst = 1'b0;
      end
      $display("random phase: 1500 cycles compared");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
